// File: rtl/conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_seq_ctrl
// Purpose  : Time-multiplexed valid-mode 2-D convolution controller. A single
//            multiply-accumulate unit is sequenced by an FSM over every output
//            position and every filter tap, one MAC per cycle. Each finished
//            output pixel is presented on a valid/ready stream.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            start           - request a convolution (accepted in IDLE only)
//            ifmap, filter   - operand arrays, captured on an accepted start
//            busy            - controller is not IDLE
//            out_valid/ready - result stream handshake
//            out_data        - convolution result for (out_row, out_col)
//            out_row/out_col - output position of out_data
//            out_last        - marks the final output position
//            done            - one-cycle pulse after the last result is taken
// Revision : 1.0 - initial release
// ============================================================================
module conv_seq_ctrl #(
    parameter  int IP_DATA_WIDTH = 8,
    parameter  int IFMAP_SIZE    = 5,
    parameter  int FILTER_SIZE   = 3,
    parameter  int STRIDE        = 1,
    parameter  int ACC_WIDTH     = 2*IP_DATA_WIDTH + $clog2(FILTER_SIZE*FILTER_SIZE),
    localparam int OFMAP_SIZE    = (IFMAP_SIZE-FILTER_SIZE)/STRIDE + 1,
    localparam int POS_WIDTH     = (OFMAP_SIZE > 1) ? $clog2(OFMAP_SIZE) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [IP_DATA_WIDTH-1:0] ifmap  [IFMAP_SIZE][IFMAP_SIZE],
    input  logic [IP_DATA_WIDTH-1:0] filter [FILTER_SIZE][FILTER_SIZE],
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_WIDTH-1:0]     out_data,
    output logic [POS_WIDTH-1:0]     out_row,
    output logic [POS_WIDTH-1:0]     out_col,
    output logic                     out_last,
    output logic                     done
);

    localparam int IDX_WIDTH  = (IFMAP_SIZE  > 1) ? $clog2(IFMAP_SIZE)  : 1;
    localparam int TAP_WIDTH  = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
    localparam int PROD_WIDTH = 2*IP_DATA_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [TAP_WIDTH-1:0] c_tap_max = TAP_WIDTH'(FILTER_SIZE-1);
    localparam logic [POS_WIDTH-1:0] c_pos_max = POS_WIDTH'(OFMAP_SIZE-1);

    logic [1:0]               state_q, state_d;
    logic [ACC_WIDTH-1:0]     acc_q, acc_d;
    logic [POS_WIDTH-1:0]     row_q, row_d;
    logic [POS_WIDTH-1:0]     col_q, col_d;
    logic [TAP_WIDTH-1:0]     tap_j_q, tap_j_d;
    logic [TAP_WIDTH-1:0]     tap_k_q, tap_k_d;
    logic [ACC_WIDTH-1:0]     out_data_q, out_data_d;
    logic [POS_WIDTH-1:0]     out_row_q, out_row_d;
    logic [POS_WIDTH-1:0]     out_col_q, out_col_d;
    logic                     out_last_q, out_last_d;

    logic [IP_DATA_WIDTH-1:0] ifmap_q  [IFMAP_SIZE][IFMAP_SIZE];
    logic [IP_DATA_WIDTH-1:0] filter_q [FILTER_SIZE][FILTER_SIZE];

    logic [IDX_WIDTH-1:0]     w_ifm_row;
    logic [IDX_WIDTH-1:0]     w_ifm_col;
    logic [PROD_WIDTH-1:0]    w_prod;
    logic [ACC_WIDTH-1:0]     w_sum;
    logic                     w_last_tap;
    logic                     w_accept;

    assign w_accept   = (state_q == S_IDLE) && start;
    assign w_last_tap = (tap_j_q == c_tap_max) && (tap_k_q == c_tap_max);

    // Window origin plus tap offset selects the ifmap element for this MAC.
    assign w_ifm_row = IDX_WIDTH'(row_q) * IDX_WIDTH'(STRIDE) + IDX_WIDTH'(tap_j_q);
    assign w_ifm_col = IDX_WIDTH'(col_q) * IDX_WIDTH'(STRIDE) + IDX_WIDTH'(tap_k_q);

    assign w_prod = PROD_WIDTH'(ifmap_q[w_ifm_row][w_ifm_col])
                  * PROD_WIDTH'(filter_q[tap_j_q][tap_k_q]);
    assign w_sum  = acc_q + ACC_WIDTH'(w_prod);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        row_d      = row_q;
        col_d      = col_q;
        tap_j_d    = tap_j_q;
        tap_k_d    = tap_k_q;
        out_data_d = out_data_q;
        out_row_d  = out_row_q;
        out_col_d  = out_col_q;
        out_last_d = out_last_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    tap_j_d = '0;
                    tap_k_d = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                if (w_last_tap) begin
                    // Final product goes straight into the result register so
                    // the OUT state follows without an extra drain cycle.
                    out_data_d = w_sum;
                    out_row_d  = row_q;
                    out_col_d  = col_q;
                    out_last_d = (row_q == c_pos_max) && (col_q == c_pos_max);
                    state_d    = S_OUT;
                end else begin
                    acc_d = w_sum;
                    if (tap_k_q == c_tap_max) begin
                        tap_k_d = '0;
                        tap_j_d = tap_j_q + 1'b1;
                    end else begin
                        tap_k_d = tap_k_q + 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d = S_DONE;
                    end else begin
                        if (col_q == c_pos_max) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                        acc_d   = '0;
                        tap_j_d = '0;
                        tap_k_d = '0;
                        state_d = S_MAC;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            tap_j_q    <= '0;
            tap_k_q    <= '0;
            out_data_q <= '0;
            out_row_q  <= '0;
            out_col_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            row_q      <= row_d;
            col_q      <= col_d;
            tap_j_q    <= tap_j_d;
            tap_k_q    <= tap_k_d;
            out_data_q <= out_data_d;
            out_row_q  <= out_row_d;
            out_col_q  <= out_col_d;
            out_last_q <= out_last_d;
        end
    end

    // Operand storage carries no reset; it is always overwritten before use.
    always_ff @(posedge clk) begin
        if (w_accept && !rst) begin
            ifmap_q  <= ifmap;
            filter_q <= filter;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign done      = (state_q == S_DONE);
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_seq_ctrl
// Purpose  : Directed self-checking bench for conv_seq_ctrl (default sizes
//            plus a STRIDE=2 instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        out_ready = 1'b1;
    logic [7:0]  ifmap  [5][5];
    logic [7:0]  filter [3][3];

    logic        busy, out_valid, out_last, done;
    logic [19:0] out_data;
    logic [1:0]  out_row, out_col;

    logic        busy2, out_valid2, out_last2, done2;
    logic [19:0] out_data2;
    logic [0:0]  out_row2, out_col2;

    int checks   = 0;
    int failures = 0;

    int nres;
    int done_cyc;
    int busy_bad;
    int res_data [9];
    int res_row  [9];
    int res_col  [9];
    int res_last [9];
    int res_cyc  [9];
    int exp_data [9];

    always #5 clk = ~clk;

    conv_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .ifmap(ifmap), .filter(filter),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .done(done)
    );

    conv_seq_ctrl #(.STRIDE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .ifmap(ifmap), .filter(filter),
        .busy(busy2), .out_valid(out_valid2), .out_ready(1'b1),
        .out_data(out_data2), .out_row(out_row2), .out_col(out_col2),
        .out_last(out_last2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_ifmap_ramp();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                ifmap[r][c] = 8'(5*r + c);
    endtask

    task automatic set_ifmap_const(input logic [7:0] v);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                ifmap[r][c] = v;
    endtask

    task automatic set_filter_const(input logic [7:0] v);
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < 3; k++)
                filter[j][k] = v;
    endtask

    // Cycle 0 is the cycle in which start is sampled. Outputs are sampled at
    // the negative edge of each following cycle; inputs change there as well.
    task automatic run(input int stall, input bit pert, input int rst_at);
        int  stall_left;
        bit  fin;
        nres       = 0;
        done_cyc   = -1;
        busy_bad   = 0;
        stall_left = stall;
        fin        = 1'b0;
        @(negedge clk);
        start     = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 1; cyc < 300 && !fin; cyc++) begin
            @(negedge clk);
            start = pert && (cyc == 5 || cyc == 91);
            if (pert && cyc == 3) set_ifmap_const(8'd0);
            if (rst_at == cyc) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                chk("rst_busy",  busy,      0);
                chk("rst_valid", out_valid, 0);
                chk("rst_data",  out_data,  0);
                chk("rst_row",   out_row,   0);
                chk("rst_col",   out_col,   0);
                chk("rst_last",  out_last,  0);
                chk("rst_done",  done,      0);
                fin = 1'b1;
            end else if (done_cyc >= 0) begin
                chk("idle_after_done", busy, 0);
                chk("done_once",       done, 0);
                fin = 1'b1;
            end else begin
                if (busy !== 1'b1) busy_bad++;
                if (out_valid) begin
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                        chk("stall_data", out_data, 9);
                        chk("stall_pos",  {out_row, out_col}, 0);
                    end else begin
                        out_ready = 1'b1;
                        if (nres < 9) begin
                            res_data[nres] = int'(out_data);
                            res_row[nres]  = int'(out_row);
                            res_col[nres]  = int'(out_col);
                            res_last[nres] = int'(out_last);
                            res_cyc[nres]  = cyc;
                        end
                        nres++;
                    end
                end else begin
                    out_ready = 1'b1;
                end
                if (done) done_cyc = cyc;
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
        chk("run_terminated", fin, 1);
        @(negedge clk);
        chk("still_idle", busy, 0);
    endtask

    task automatic check_run(input int stall);
        chk("n_results", nres, 9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("data%0d", i), res_data[i], exp_data[i]);
            chk($sformatf("row%0d",  i), res_row[i],  i / 3);
            chk($sformatf("col%0d",  i), res_col[i],  i % 3);
            chk($sformatf("last%0d", i), res_last[i], (i == 8) ? 1 : 0);
            chk($sformatf("hs_cyc%0d", i), res_cyc[i], 10*(i+1) + stall);
        end
        chk("done_cycle", done_cyc, 91 + stall);
        chk("busy_span",  busy_bad, 0);
    endtask

    initial begin
        int s2_n;
        int s2_done;
        int s2_exp [4];
        s2_exp = '{54, 72, 144, 162};

        set_ifmap_const(8'd1);
        set_filter_const(8'd1);
        repeat (2) @(negedge clk);
        chk("reset_busy",  busy,      0);
        chk("reset_valid", out_valid, 0);
        chk("reset_data",  out_data,  0);
        chk("reset_row",   out_row,   0);
        chk("reset_col",   out_col,   0);
        chk("reset_last",  out_last,  0);
        chk("reset_done",  done,      0);
        rst = 1'b0;
        @(negedge clk);

        // All ones: every window sums nine 1*1 products.
        for (int i = 0; i < 9; i++) exp_data[i] = 9;
        run(0, 1'b0, -1);
        check_run(0);

        // Ramp ifmap with a centre-only filter picks ifmap[r+1][c+1].
        set_ifmap_ramp();
        set_filter_const(8'd0);
        filter[1][1] = 8'd1;
        exp_data = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
        run(0, 1'b0, -1);
        check_run(0);

        // Full-scale operands: 9 * 255 * 255 must not truncate.
        set_ifmap_const(8'd255);
        set_filter_const(8'd255);
        for (int i = 0; i < 9; i++) exp_data[i] = 585225;
        run(0, 1'b0, -1);
        check_run(0);

        // Backpressure on the first result, and ifmap zeroed while busy.
        set_ifmap_const(8'd1);
        set_filter_const(8'd1);
        for (int i = 0; i < 9; i++) exp_data[i] = 9;
        run(4, 1'b1, -1);
        check_run(4);

        // Stray start pulses in cycles 5 and 91 must not restart the run.
        set_ifmap_const(8'd1);
        run(0, 1'b1, -1);
        check_run(0);

        // Reset in the middle of a run, then a clean run afterwards.
        set_ifmap_const(8'd1);
        run(0, 1'b0, 35);
        chk("post_rst_no_done", done, 0);
        run(0, 1'b0, -1);
        check_run(0);

        // STRIDE=2 instance: 2x2 outputs from the ramp ifmap.
        set_ifmap_ramp();
        set_filter_const(8'd1);
        s2_n    = 0;
        s2_done = -1;
        @(negedge clk);
        start2 = 1'b1;
        for (int cyc = 1; cyc < 100 && s2_done < 0; cyc++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (out_valid2) begin
                if (s2_n < 4) begin
                    chk($sformatf("s2_data%0d", s2_n), out_data2, s2_exp[s2_n]);
                    chk($sformatf("s2_pos%0d",  s2_n), {out_row2, out_col2}, s2_n);
                    chk($sformatf("s2_last%0d", s2_n), out_last2, (s2_n == 3) ? 1 : 0);
                end
                s2_n++;
            end
            if (done2) s2_done = cyc;
        end
        chk("s2_count",     s2_n,    4);
        chk("s2_done_cyc",  s2_done, 41);
        @(negedge clk);
        chk("s2_idle", busy2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
